graph_mem_server: RTL and testbench

//  Responder end of the graph-fetch memory request interface. Serves two independent read

---
 rtl/graph_pkg.sv | 11 +
 rtl/graph_mem_server_if.sv | 31 +++
 rtl/graph_mem_array.sv | 34 +++
 rtl/graph_mem_server.sv | 134 +++++++++++++
 tb/tb_graph_mem_server.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/graph_pkg.sv
// Shared widths, the null-neighbour word and the server FSM states for the graph memory server.
package graph_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [DATA_W-1:0] NULL_VERTEX = 32'd0;

  typedef enum logic {
    CLEAR,
    READY
  } srv_state_t;
endpackage

// File: rtl/graph_mem_server_if.sv
// Fetcher-facing bundle: two read request/response ports, host load port, status.
interface graph_mem_server_if;
  logic                         ready_out;
  logic                         mem_valid_in;
  logic [graph_pkg::ADDR_W-1:0] mem_req_in;
  logic                         mem_valid_out;
  logic [graph_pkg::DATA_W-1:0] mem_data_out;
  logic                         mem_valid_in2;
  logic [graph_pkg::ADDR_W-1:0] mem_req_in2;
  logic                         mem_valid_out2;
  logic [graph_pkg::DATA_W-1:0] mem_data_out2;
  logic                         load_valid_in;
  logic [graph_pkg::ADDR_W-1:0] load_addr_in;
  logic [graph_pkg::DATA_W-1:0] load_data_in;
  logic                         load_ready_out;
  logic                         oor_err_out;

  modport slave (
    output ready_out, mem_valid_out, mem_data_out, mem_valid_out2, mem_data_out2,
           load_ready_out, oor_err_out,
    input  mem_valid_in, mem_req_in, mem_valid_in2, mem_req_in2,
           load_valid_in, load_addr_in, load_data_in
  );

  modport master (
    input  ready_out, mem_valid_out, mem_data_out, mem_valid_out2, mem_data_out2,
           load_ready_out, oor_err_out,
    output mem_valid_in, mem_req_in, mem_valid_in2, mem_req_in2,
           load_valid_in, load_addr_in, load_data_in
  );
endinterface

// File: rtl/graph_mem_array.sv
// Graph image storage: 1 write port, 2 read ports with registered read-first outputs.
// One cycle read latency, no backpressure, storage is not reset.
module graph_mem_array
  import graph_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr1_i,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata1_q, rdata2_q;

  // Reads sample the array before this edge's write lands, so a same-cycle collision returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata1_q <= mem_q[raddr1_i];
    rdata2_q <= mem_q[raddr2_i];
  end

  assign rdata1_o = rdata1_q;
  assign rdata2_o = rdata2_q;

endmodule

// File: rtl/graph_mem_server.sv
// Dual-port graph image responder: zero-fill sweep after reset, then LATENCY-cycle reads and host loads.
// No backpressure: every request accepted in READY is answered exactly LATENCY cycles later.
module graph_mem_server
  import graph_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  graph_mem_server_if.slave  bus
);

  localparam int                AW      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  srv_state_t        state_q, state_d;
  logic [AW-1:0]     clear_ptr_q, clear_ptr_d;
  logic              err_q, err_d;
  logic              ready;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        acc;
  logic [1:0]        req_oor;
  logic              load_oor;
  logic [DATA_W-1:0] rd_dat [2];
  logic [1:0]        rsp_vld;
  logic [DATA_W-1:0] rsp_dat [2];

  assign ready      = (state_q == READY);
  assign req_oor[0] = (bus.mem_req_in  >= DEPTH_A);
  assign req_oor[1] = (bus.mem_req_in2 >= DEPTH_A);
  assign load_oor   = (bus.load_addr_in >= DEPTH_A);
  assign acc[0]     = ready & bus.mem_valid_in;
  assign acc[1]     = ready & bus.mem_valid_in2;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= CLEAR;
      clear_ptr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      err_q       <= err_d;
    end
  end

  // The sweep owns the write port until READY; host loads take it over afterwards.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    we          = 1'b0;
    waddr       = clear_ptr_q;
    wdata       = NULL_VERTEX;
    case (state_q)
      CLEAR: begin
        we          = 1'b1;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == AW'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        we    = bus.load_valid_in & ~load_oor;
        waddr = bus.load_addr_in[AW-1:0];
        wdata = bus.load_data_in;
      end
      default: state_d = CLEAR;
    endcase
    err_d = err_q | (|(acc & req_oor)) | (ready & bus.load_valid_in & load_oor);
  end

  graph_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i    (clk_in),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .raddr1_i (bus.mem_req_in[AW-1:0]),
    .raddr2_i (bus.mem_req_in2[AW-1:0]),
    .rdata1_o (rd_dat[0]),
    .rdata2_o (rd_dat[1])
  );

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] oor_q;
    logic [DATA_W-1:0]  dat_last;

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        vld_q <= '0;
        oor_q <= '0;
      end else begin
        vld_q[0] <= acc[p];
        oor_q[0] <= acc[p] & req_oor[p];
        for (int k = 1; k < LATENCY; k++) begin
          vld_q[k] <= vld_q[k-1];
          oor_q[k] <= oor_q[k-1];
        end
      end
    end

    // The array register is stage 1; extra stages only delay the data, which is masked by valid.
    if (LATENCY > 1) begin : g_dly
      logic [DATA_W-1:0] dat_q [LATENCY-1];
      always_ff @(posedge clk_in) begin
        dat_q[0] <= rd_dat[p];
        for (int k = 1; k < LATENCY - 1; k++) begin
          dat_q[k] <= dat_q[k-1];
        end
      end
      assign dat_last = dat_q[LATENCY-2];
    end else begin : g_nodly
      assign dat_last = rd_dat[p];
    end

    assign rsp_vld[p] = vld_q[LATENCY-1];
    assign rsp_dat[p] = (vld_q[LATENCY-1] && !oor_q[LATENCY-1]) ? dat_last : NULL_VERTEX;
  end

  assign bus.ready_out      = ready;
  assign bus.load_ready_out = ready;
  assign bus.oor_err_out    = err_q;
  assign bus.mem_valid_out  = rsp_vld[0];
  assign bus.mem_data_out   = rsp_dat[0];
  assign bus.mem_valid_out2 = rsp_vld[1];
  assign bus.mem_data_out2  = rsp_dat[1];

endmodule

// File: tb/tb_graph_mem_server.sv
// Bench for graph_mem_server (DEPTH=16, LATENCY=2): directed scenarios plus random traffic vs a queue model.
module tb_graph_mem_server;
  import graph_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  graph_mem_server_if bus ();

  graph_mem_server #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] dat;
  } rsp_t;

  rsp_t        q1[$];
  rsp_t        q2[$];
  logic [31:0] mem_m [DEPTH];
  bit          ready_m;
  bit          err_m;
  int          clear_cnt;
  int          edge_n;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a < DEPTH) ? mem_m[int'(a)] : 32'd0;
  endfunction

  // Applies the rules to the inputs about to be sampled at the next rising edge.
  task automatic model_edge();
    rsp_t r;
    edge_n++;
    if (ready_m) begin
      if (bus.mem_valid_in) begin
        if (bus.mem_req_in >= DEPTH) err_m = 1'b1;
        r.due = edge_n + LAT - 1;
        r.dat = rd_model(bus.mem_req_in);
        q1.push_back(r);
      end
      if (bus.mem_valid_in2) begin
        if (bus.mem_req_in2 >= DEPTH) err_m = 1'b1;
        r.due = edge_n + LAT - 1;
        r.dat = rd_model(bus.mem_req_in2);
        q2.push_back(r);
      end
      if (bus.load_valid_in) begin
        if (bus.load_addr_in >= DEPTH) err_m = 1'b1;
        else mem_m[int'(bus.load_addr_in)] = bus.load_data_in;
      end
    end else begin
      clear_cnt++;
      if (clear_cnt == DEPTH) begin
        ready_m = 1'b1;
        foreach (mem_m[i]) mem_m[i] = 32'd0;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_eq("ready_out", 32'(bus.ready_out), 32'(ready_m));
    check_eq("load_ready_out", 32'(bus.load_ready_out), 32'(ready_m));
    check_eq("oor_err_out", 32'(bus.oor_err_out), 32'(err_m));
    if (q1.size() > 0 && q1[0].due == edge_n) begin
      check_eq("p1_valid", 32'(bus.mem_valid_out), 32'd1);
      check_eq("p1_data", bus.mem_data_out, q1[0].dat);
      void'(q1.pop_front());
    end else begin
      check_eq("p1_valid", 32'(bus.mem_valid_out), 32'd0);
    end
    if (q2.size() > 0 && q2[0].due == edge_n) begin
      check_eq("p2_valid", 32'(bus.mem_valid_out2), 32'd1);
      check_eq("p2_data", bus.mem_data_out2, q2[0].dat);
      void'(q2.pop_front());
    end else begin
      check_eq("p2_valid", 32'(bus.mem_valid_out2), 32'd0);
    end
  endtask

  task automatic idle();
    bus.mem_valid_in  = 1'b0;
    bus.mem_req_in    = '0;
    bus.mem_valid_in2 = 1'b0;
    bus.mem_req_in2   = '0;
    bus.load_valid_in = 1'b0;
    bus.load_addr_in  = '0;
    bus.load_data_in  = '0;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic rand_inputs();
    bus.mem_valid_in  = 1'($urandom_range(1, 0));
    bus.mem_req_in    = 32'($urandom_range(DEPTH + 3, 0));
    bus.mem_valid_in2 = 1'($urandom_range(1, 0));
    bus.mem_req_in2   = 32'($urandom_range(DEPTH + 3, 0));
    bus.load_valid_in = 1'($urandom_range(1, 0));
    bus.load_addr_in  = 32'($urandom_range(DEPTH + 1, 0));
    bus.load_data_in  = $urandom;
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    ready_m   = 1'b0;
    err_m     = 1'b0;
    clear_cnt = 0;
  endtask

  // Called just after a checked edge; reset is asserted and released before the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_p1_valid", 32'(bus.mem_valid_out), 32'd0);
    check_eq("rst_p2_valid", 32'(bus.mem_valid_out2), 32'd0);
    check_eq("rst_p1_data", bus.mem_data_out, 32'd0);
    check_eq("rst_ready", 32'(bus.ready_out), 32'd0);
    check_eq("rst_oor", 32'(bus.oor_err_out), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    model_reset();
    edge_n = 0;
    @(posedge clk);
    #1;
    check_eq("init_ready", 32'(bus.ready_out), 32'd0);
    check_eq("init_p1_valid", 32'(bus.mem_valid_out), 32'd0);
    check_eq("init_p2_data", bus.mem_data_out2, 32'd0);
    check_eq("init_oor", 32'(bus.oor_err_out), 32'd0);
    rst_n = 1'b1;

    // Sweep length and first read of a cleared word.
    idle_cycles(DEPTH - 1);
    check_eq("ready_before_sweep_end", 32'(bus.ready_out), 32'd0);
    cycle();
    check_eq("ready_after_sweep", 32'(bus.ready_out), 32'd1);
    bus.mem_valid_in = 1'b1; bus.mem_req_in = 32'd7;
    cycle();
    idle_cycles(1);
    check_eq("clear_addr7_valid", 32'(bus.mem_valid_out), 32'd1);
    check_eq("clear_addr7_data", bus.mem_data_out, 32'd0);
    idle_cycles(2);

    // Load then read back.
    bus.load_valid_in = 1'b1; bus.load_addr_in = 32'd5; bus.load_data_in = 32'h0000_1234;
    cycle();
    idle();
    bus.mem_valid_in = 1'b1; bus.mem_req_in = 32'd5;
    cycle();
    idle_cycles(1);
    check_eq("load5_data", bus.mem_data_out, 32'h0000_1234);
    idle_cycles(2);

    // Streamed reads on both ports.
    for (int i = 1; i <= 6; i++) begin
      idle();
      bus.load_valid_in = 1'b1; bus.load_addr_in = 32'(i); bus.load_data_in = 32'(10 + i);
      cycle();
    end
    idle();
    bus.mem_valid_in  = 1'b1; bus.mem_req_in  = 32'd1;
    bus.mem_valid_in2 = 1'b1; bus.mem_req_in2 = 32'd3;
    cycle();
    bus.mem_req_in = 32'd2; bus.mem_req_in2 = 32'd4;
    cycle();
    bus.mem_valid_in = 1'b0; bus.mem_req_in2 = 32'd5;
    cycle();
    idle_cycles(3);

    // Read-first collision.
    bus.load_valid_in = 1'b1; bus.load_addr_in = 32'd9; bus.load_data_in = 32'hAA;
    cycle();
    bus.load_data_in = 32'hBB;
    bus.mem_valid_in = 1'b1; bus.mem_req_in = 32'd9;
    cycle();
    bus.load_valid_in = 1'b0;
    cycle();
    check_eq("collide_old", bus.mem_data_out, 32'hAA);
    idle_cycles(1);
    check_eq("collide_new", bus.mem_data_out, 32'hBB);
    idle_cycles(2);

    // Out-of-range read on port 2.
    check_eq("oor_before", 32'(bus.oor_err_out), 32'd0);
    bus.mem_valid_in2 = 1'b1; bus.mem_req_in2 = 32'(DEPTH);
    cycle();
    idle();
    check_eq("oor_t1", 32'(bus.oor_err_out), 32'd1);
    cycle();
    check_eq("oor_rsp_valid", 32'(bus.mem_valid_out2), 32'd1);
    check_eq("oor_rsp_data", bus.mem_data_out2, 32'd0);
    idle_cycles(3);
    check_eq("oor_held", 32'(bus.oor_err_out), 32'd1);

    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      cycle();
    end
    idle_cycles(3);

    // Reset with requests in flight, noisy traffic during the rerun sweep.
    bus.mem_valid_in  = 1'b1; bus.mem_req_in  = 32'd1;
    bus.mem_valid_in2 = 1'b1; bus.mem_req_in2 = 32'd2;
    cycle();
    cycle();
    check_eq("inflight_visible", 32'(bus.mem_valid_out), 32'd1);
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      rand_inputs();
      cycle();
    end
    check_eq("ready_after_rerun", 32'(bus.ready_out), 32'd1);
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      cycle();
    end
    idle_cycles(4);
    check_eq("q1_drained", 32'(q1.size()), 32'd0);
    check_eq("q2_drained", 32'(q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
